// File: rtl/mul6_pkg.sv
// Shared widths and FSM encoding for the 6x6 shift-and-add multiplier controller.
package mul6_pkg;

  localparam int MUL6_W     = 6;
  localparam int MUL6_P_W   = 12;
  localparam int MUL6_CNT_W = 3;
  localparam int MUL6_ITER  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul6_state_t;

endpackage

// File: rtl/cla6.sv
// 6-bit carry-lookahead adder: every carry is a flat sum of generate/propagate products.
module cla6 (
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       ci,
  output logic [5:0] sum,
  output logic       co
);

  logic [5:0] g;
  logic [5:0] p;
  logic [6:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = ci;

  for (genvar gi = 0; gi < 6; gi++) begin : g_carry
    logic carry_n;
    logic term;

    // c[gi+1] = ci&p[gi:0] | OR_j ( g[j] & p[gi:j+1] )
    always_comb begin
      carry_n = ci;
      term    = 1'b0;
      for (int k = 0; k <= gi; k++) carry_n = carry_n & p[k];
      for (int j = 0; j <= gi; j++) begin
        term = g[j];
        for (int k = j + 1; k <= gi; k++) term = term & p[k];
        carry_n = carry_n | term;
      end
    end

    assign c[gi+1] = carry_n;
  end

  assign sum = p ^ c[5:0];
  assign co  = c[6];

endmodule

// File: rtl/mul6_ctrl.sv
// Sequential 6x6 unsigned shift-and-add multiplier on a shared cla6 adder.
// Optional build macro MUL6_ZERO_SKIP_EN: zero operands finish one cycle after the start.
module mul6_ctrl
  import mul6_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                op_start,
  input  logic [MUL6_W-1:0]   op_a,
  input  logic [MUL6_W-1:0]   op_b,
  output logic                op_busy,
  output logic                op_done,
  output logic [MUL6_P_W-1:0] result
);

  mul6_state_t           state_reg;
  mul6_state_t           state_next;
  logic [MUL6_W-1:0]     mcand_reg;
  logic [MUL6_W-1:0]     acc_hi_reg;
  logic [MUL6_W-1:0]     acc_lo_reg;
  logic [MUL6_CNT_W-1:0] cnt_reg;

  logic [MUL6_W-1:0] add_sum;
  logic              add_co;
  logic              start_ok;
  logic              start_zero;
  logic              last_iter;

  cla6 u_cla6 (
    .a   (acc_hi_reg),
    .b   (mcand_reg),
    .ci  (1'b0),
    .sum (add_sum),
    .co  (add_co)
  );

  // Starts are only honoured while not iterating.
  assign start_ok  = op_start && (state_reg != ST_CALC);
  assign last_iter = (cnt_reg == MUL6_CNT_W'(MUL6_ITER - 1));

`ifdef MUL6_ZERO_SKIP_EN
  assign start_zero = (op_a == '0) || (op_b == '0);
`else
  assign start_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE,
      ST_DONE: begin
        if (op_start) state_next = start_zero ? ST_DONE : ST_CALC;
        else          state_next = ST_IDLE;
      end
      ST_CALC: if (last_iter) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    op_busy = 1'b0;
    op_done = 1'b0;
    case (state_reg)
      ST_CALC: op_busy = 1'b1;
      ST_DONE: op_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_reg  <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      cnt_reg    <= '0;
    end else if (state_reg == ST_CALC) begin
      // Adder carry-out shifts in at the top, so bit 11 never overflows.
      if (acc_lo_reg[0]) {acc_hi_reg, acc_lo_reg} <= {add_co, add_sum, acc_lo_reg[MUL6_W-1:1]};
      else               {acc_hi_reg, acc_lo_reg} <= {1'b0, acc_hi_reg, acc_lo_reg[MUL6_W-1:1]};
      cnt_reg <= cnt_reg + 1'b1;
    end else if (start_ok) begin
      mcand_reg  <= op_a;
      acc_hi_reg <= '0;
      acc_lo_reg <= start_zero ? '0 : op_b;
      cnt_reg    <= '0;
    end
  end

  assign result = {acc_hi_reg, acc_lo_reg};

endmodule

// File: tb/tb_mul6_ctrl.sv
// Directed bench for mul6_ctrl: handshake timing, boundaries, abort and full operand sweep.
module tb_mul6_ctrl;

  logic        clk;
  logic        reset_n;
  logic        op_start;
  logic [5:0]  op_a;
  logic [5:0]  op_b;
  logic        op_busy;
  logic        op_done;
  logic [11:0] result;

  int vectors;
  int miscompares;

`ifdef MUL6_ZERO_SKIP_EN
  localparam int ZERO_LAT  = 0;
  localparam int ZERO_BUSY = 0;
`else
  localparam int ZERO_LAT  = 6;
  localparam int ZERO_BUSY = 6;
`endif

  mul6_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op_start (op_start),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_busy  (op_busy),
    .op_done  (op_done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [5:0] a, input logic [5:0] b);
    op_start = 1'b1;
    op_a     = a;
    op_b     = b;
    tick();
    op_start = 1'b0;
    op_a     = 6'h2A;
    op_b     = 6'h15;
  endtask

  // Ticks until op_done is seen; lat counts ticks after the accepting edge.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!op_done && lat < 20) begin
      if (op_busy) busy_cnt++;
      tick();
      lat++;
    end
    if (!op_done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: op_done=%0b after %0d cycles, required 1", op_done, lat);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    op_start = 1'b0;
    op_a     = '0;
    op_b     = '0;
    tick();
    tick();
    vectors++;
    if ({op_busy, op_done, result} !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%0b done=%0b result=%h, required 0 0 000", op_busy, op_done, result);
    end
    reset_n = 1'b1;
    tick();
    vectors++;
    if ({op_busy, op_done, result} !== 14'h0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%0b done=%0b result=%h, required 0 0 000", op_busy, op_done, result);
    end
    $display("reset: busy=%0b done=%0b result=%h", op_busy, op_done, result);
  endtask

  task automatic test_basic();
    int lat, bc;
    start_op(6'd5, 6'd3);
    wait_done(lat, bc);
    vectors++;
    if (result !== 12'd15) begin
      miscompares++;
      $display("FAIL basic_result: got %0d, required 15", result);
    end
    vectors++;
    if (lat !== 6) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d, required 6", lat);
    end
    vectors++;
    if (bc !== 6) begin
      miscompares++;
      $display("FAIL basic_busy_cycles: got %0d, required 6", bc);
    end
    tick();
    tick();
    vectors++;
    if ({op_busy, op_done, result} !== {2'b00, 12'd15}) begin
      miscompares++;
      $display("FAIL basic_hold: busy=%0b done=%0b result=%0d, required 0 0 15", op_busy, op_done, result);
    end
    $display("5x3: result=%0d latency=%0d busy=%0d", result, lat, bc);
  endtask

  task automatic test_max();
    int lat, bc;
    start_op(6'd63, 6'd63);
    wait_done(lat, bc);
    vectors++;
    if (result !== 12'hF81) begin
      miscompares++;
      $display("FAIL max_result: got %h, required f81", result);
    end
    tick();
    $display("63x63: result=%h latency=%0d", result, lat);
  endtask

  task automatic test_zero();
    int lat, bc;
    start_op(6'd0, 6'd45);
    wait_done(lat, bc);
    vectors++;
    if (result !== 12'd0) begin
      miscompares++;
      $display("FAIL zero_result: got %0d, required 0", result);
    end
    vectors++;
    if (lat !== ZERO_LAT) begin
      miscompares++;
      $display("FAIL zero_latency: got %0d, required %0d", lat, ZERO_LAT);
    end
    vectors++;
    if (bc !== ZERO_BUSY) begin
      miscompares++;
      $display("FAIL zero_busy_cycles: got %0d, required %0d", bc, ZERO_BUSY);
    end
    tick();
    $display("0x45: result=%0d latency=%0d busy=%0d", result, lat, bc);
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    start_op(6'd7, 6'd9);
    tick();
    start_op(6'd2, 6'd2);
    wait_done(lat, bc);
    vectors++;
    if (result !== 12'd63) begin
      miscompares++;
      $display("FAIL ignore_start_result: got %0d, required 63", result);
    end
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL ignore_start_latency: got %0d, required 4", lat);
    end
    start_op(6'd4, 6'd4);
    vectors++;
    if ({op_busy, op_done} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%0b done=%0b, required 1 0", op_busy, op_done);
    end
    wait_done(lat, bc);
    vectors++;
    if (result !== 12'd16) begin
      miscompares++;
      $display("FAIL b2b_result: got %0d, required 16", result);
    end
    vectors++;
    if (lat + 1 !== 7) begin
      miscompares++;
      $display("FAIL b2b_spacing: got %0d, required 7", lat + 1);
    end
    tick();
    $display("7x9 then 4x4: result=%0d spacing=%0d", result, lat + 1);
  endtask

  task automatic test_reset_abort();
    int lat, bc, dones;
    start_op(6'd10, 6'd10);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({op_busy, op_done, result} !== 14'h0) begin
      miscompares++;
      $display("FAIL abort_outputs: busy=%0b done=%0b result=%h, required 0 0 000", op_busy, op_done, result);
    end
    tick();
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (op_done) dones++;
      tick();
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d pulses, required 0", dones);
    end
    start_op(6'd6, 6'd7);
    wait_done(lat, bc);
    vectors++;
    if (result !== 12'd42) begin
      miscompares++;
      $display("FAIL abort_recover: got %0d, required 42", result);
    end
    tick();
    $display("abort then 6x7: result=%0d", result);
  endtask

  task automatic test_sweep();
    int lat, bc, bad;
    int exp_lat;
    bad = 0;
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        start_op(6'(a), 6'(b));
        wait_done(lat, bc);
        exp_lat = (a == 0 || b == 0) ? ZERO_LAT : 6;
        vectors++;
        if (result !== 12'(a * b) || lat !== exp_lat) begin
          miscompares++;
          bad++;
          $display("FAIL sweep %0dx%0d: result=%0d latency=%0d, required %0d latency %0d",
                   a, b, result, lat, a * b, exp_lat);
        end
        if (((a + b) % 5) == 0) tick();
      end
    end
    tick();
    $display("sweep: 4096 pairs, %0d bad", bad);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
